// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_packer
// Purpose  : Packs NIB_PER_WORD nibbles per word into a first-word-fall-through
//            FIFO with valid/ready output and a sticky overflow flag.
//            Optional sequence checker enabled by macro SEQ_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_packer #(
    parameter int NIB_PER_WORD = 4,
    parameter int DEPTH        = 4,
    parameter int SEQ_MOD      = 8
) (
    input  logic                      clk_b,
    input  logic                      rst_n,
    input  logic [3:0]                nib_in,
    input  logic                      nib_vld,
    output logic [4*NIB_PER_WORD-1:0] word_out,
    output logic                      word_vld,
    input  logic                      word_rdy,
    output logic                      fifo_full,
    output logic                      overflow,
    output logic                      seq_err,
    output logic [7:0]                err_cnt
);

    localparam int c_W     = 4 * NIB_PER_WORD;
    localparam int c_IDX_W = $clog2(NIB_PER_WORD);
    localparam int c_AW    = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIB_PER_WORD - 1);

    if (NIB_PER_WORD < 2 || NIB_PER_WORD > 8) begin : g_chk_nib
        $error("nibble_packer: NIB_PER_WORD out of range");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("nibble_packer: DEPTH must be a power of two in 2..16");
    end
    if (SEQ_MOD < 2 || SEQ_MOD > 16) begin : g_chk_mod
        $error("nibble_packer: SEQ_MOD out of range");
    end

    logic [c_IDX_W-1:0] r_idx;
    logic [c_W-1:0]     r_asm;
    logic               r_push_req;
    logic [c_W-1:0]     r_mem [DEPTH];
    logic [c_AW:0]      r_wptr;
    logic [c_AW:0]      r_rptr;
    logic               r_full;
    logic               r_vld;
    logic               r_ovf;

    logic               w_pop;
    logic               w_push_ok;
    logic [c_AW:0]      w_wptr_nxt;
    logic [c_AW:0]      w_rptr_nxt;

    // Assembly never stalls; the completed word is pushed on the following
    // clock, so a new word may begin filling slot 0 at the same edge.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_asm      <= '0;
            r_push_req <= 1'b0;
        end else begin
            r_push_req <= nib_vld && (r_idx == c_LAST_IDX);
            if (nib_vld) begin
                r_asm[{r_idx, 2'b00} +: 4] <= nib_in;
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_pop      = r_vld && word_rdy;
        w_push_ok  = r_push_req && (!r_full || w_pop);
        w_wptr_nxt = w_push_ok ? r_wptr + 1'b1 : r_wptr;
        w_rptr_nxt = w_pop ? r_rptr + 1'b1 : r_rptr;
    end

    always_ff @(posedge clk_b) begin
        if (w_push_ok) begin
            r_mem[r_wptr[c_AW-1:0]] <= r_asm;
        end
    end

    // Flags are computed from the next pointers so they land on the same edge.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_full <= 1'b0;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_full <= (w_wptr_nxt[c_AW] != w_rptr_nxt[c_AW]) &&
                      (w_wptr_nxt[c_AW-1:0] == w_rptr_nxt[c_AW-1:0]);
            r_vld  <= (w_wptr_nxt != w_rptr_nxt);
            if (r_push_req && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign word_out  = r_vld ? r_mem[r_rptr[c_AW-1:0]] : '0;
    assign word_vld  = r_vld;
    assign fifo_full = r_full;
    assign overflow  = r_ovf;

`ifdef SEQ_CHECK_EN
    localparam logic [4:0] c_SEQ_MOD = 5'(SEQ_MOD);

    logic       r_synced;
    logic [3:0] r_exp;
    logic       r_seq_err;
    logic [7:0] r_err_cnt;
    logic [4:0] w_nib_inc;
    logic       w_mismatch;

    always_comb begin
        w_nib_inc  = {1'b0, nib_in} + 5'd1;
        w_mismatch = ({1'b0, nib_in} >= c_SEQ_MOD) || (r_synced && (nib_in != r_exp));
    end

    // Every nibble re-seeds the expectation, which gives resync for free.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_synced  <= 1'b0;
            r_exp     <= '0;
            r_seq_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_seq_err <= nib_vld && w_mismatch;
            if (nib_vld) begin
                r_synced <= 1'b1;
                r_exp    <= 4'(w_nib_inc % c_SEQ_MOD);
                if (w_mismatch && r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign seq_err = r_seq_err;
    assign err_cnt = r_err_cnt;
`else
    assign seq_err = 1'b0;
    assign err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_packer
// Purpose  : Directed self-checking bench for nibble_packer (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_packer;

    logic        clk_b = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  nib_in = 4'h0;
    logic        nib_vld = 1'b0;
    logic [15:0] word_out;
    logic        word_vld;
    logic        word_rdy = 1'b0;
    logic        fifo_full;
    logic        overflow;
    logic        seq_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk_b = ~clk_b;

    nibble_packer #(
        .NIB_PER_WORD(4),
        .DEPTH       (4),
        .SEQ_MOD     (8)
    ) dut (
        .clk_b    (clk_b),
        .rst_n    (rst_n),
        .nib_in   (nib_in),
        .nib_vld  (nib_vld),
        .word_out (word_out),
        .word_vld (word_vld),
        .word_rdy (word_rdy),
        .fifo_full(fifo_full),
        .overflow (overflow),
        .seq_err  (seq_err),
        .err_cnt  (err_cnt)
    );

    // All stimulus changes and samples happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_b);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_in  = n;
        nib_vld = 1'b1;
        tick();
        nib_vld = 1'b0;
    endtask

    task automatic apply_reset();
        nib_vld  = 1'b0;
        word_rdy = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({word_vld, fifo_full, overflow, seq_err, err_cnt, word_out} !== 28'h0) begin
            bad++;
            $display("FAIL reset_outputs: got vld=%b full=%b ovf=%b err=%b cnt=%0d out=%h, want all 0",
                     word_vld, fifo_full, overflow, seq_err, err_cnt, word_out);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [3:0] nibs [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        apply_reset();
        word_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_nib(nibs[i]);
            total++;
            if (seq_err !== 1'b0) begin
                bad++;
                $display("FAIL basic_seq_err: nibble %0d got %b want 0", i, seq_err);
            end
        end
        total++;
        if (word_vld !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: word_vld=%b one edge after last strobe, want 0", word_vld);
        end
        tick();
        total++;
        if (word_vld !== 1'b1 || word_out !== 16'h4321) begin
            bad++;
            $display("FAIL basic_word: vld=%b out=%h, want 1 / 4321", word_vld, word_out);
        end
        tick();
        total++;
        if (word_vld !== 1'b0) begin
            bad++;
            $display("FAIL basic_one_cycle: word_vld=%b after pop, want 0", word_vld);
        end
        word_rdy = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] exp [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        apply_reset();
        for (int i = 0; i < 16; i++) send_nib(4'(i));
        tick();
        total++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_full4: full=%b ovf=%b, want 1 / 0", fifo_full, overflow);
        end
        for (int i = 0; i < 4; i++) send_nib(4'(i));
        tick();
        total++;
        if (overflow !== 1'b1 || fifo_full !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drop: ovf=%b full=%b, want 1 / 1", overflow, fifo_full);
        end
        tick();
        total++;
        if (word_out !== exp[0]) begin
            bad++;
            $display("FAIL ovf_hold: out=%h with rdy=0, want %h", word_out, exp[0]);
        end
        word_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (word_vld !== 1'b1 || word_out !== exp[k]) begin
                bad++;
                $display("FAIL ovf_drain%0d: vld=%b out=%h, want 1 / %h", k, word_vld, word_out, exp[k]);
            end
            tick();
        end
        total++;
        if (word_vld !== 1'b0 || overflow !== 1'b1 || fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL ovf_after: vld=%b ovf=%b full=%b, want 0 / 1 / 0", word_vld, overflow, fifo_full);
        end
        word_rdy = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [15:0] exp [5] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h8765};
        apply_reset();
        for (int i = 0; i < 16; i++) send_nib(4'(i));
        tick();
        send_nib(4'h5);
        send_nib(4'h6);
        send_nib(4'h7);
        send_nib(4'h8);
        word_rdy = 1'b1;
        tick();
        word_rdy = 1'b0;
        total++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0 || word_out !== exp[1]) begin
            bad++;
            $display("FAIL fullpop_same: full=%b ovf=%b out=%h, want 1 / 0 / %h",
                     fifo_full, overflow, word_out, exp[1]);
        end
        word_rdy = 1'b1;
        for (int k = 1; k < 5; k++) begin
            total++;
            if (word_vld !== 1'b1 || word_out !== exp[k]) begin
                bad++;
                $display("FAIL fullpop_drain%0d: vld=%b out=%h, want 1 / %h", k, word_vld, word_out, exp[k]);
            end
            tick();
        end
        total++;
        if (word_vld !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fullpop_end: vld=%b ovf=%b, want 0 / 0", word_vld, overflow);
        end
        word_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        int words = 0;
        apply_reset();
        word_rdy = 1'b1;
        send_nib(4'h3);
        send_nib(4'h4);
        rst_n = 1'b0;
        #1;
        total++;
        if (word_vld !== 1'b0) begin
            bad++;
            $display("FAIL midrst_vld: word_vld=%b during reset, want 0", word_vld);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_nib(4'h5);
        send_nib(4'h6);
        send_nib(4'h7);
        send_nib(4'h0);
        for (int c = 0; c < 6; c++) begin
            if (word_vld === 1'b1) begin
                words++;
                total++;
                if (word_out !== 16'h0765) begin
                    bad++;
                    $display("FAIL midrst_word: out=%h, want 0765", word_out);
                end
            end
            tick();
        end
        total++;
        if (words != 1) begin
            bad++;
            $display("FAIL midrst_count: %0d words output, want 1", words);
        end
        word_rdy = 1'b0;
    endtask

`ifdef SEQ_CHECK_EN
    task automatic test_seq_check();
        logic [3:0] nibs [5] = '{4'h6, 4'h7, 4'h0, 4'h2, 4'h3};
        logic       errs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        word_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_nib(nibs[i]);
            total++;
            if (seq_err !== errs[i]) begin
                bad++;
                $display("FAIL seq_pulse%0d: nibble %h seq_err=%b, want %b", i, nibs[i], seq_err, errs[i]);
            end
        end
        tick();
        total++;
        if (seq_err !== 1'b0 || err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL seq_count: seq_err=%b err_cnt=%0d, want 0 / 1", seq_err, err_cnt);
        end
        word_rdy = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        word_rdy = 1'b1;
        for (int i = 0; i < 255; i++) send_nib(4'h0);
        total++;
        if (err_cnt !== 8'd254) begin
            bad++;
            $display("FAIL sat_254: err_cnt=%0d after 254 mismatches, want 254", err_cnt);
        end
        for (int i = 0; i < 45; i++) send_nib(4'h0);
        total++;
        if (err_cnt !== 8'd255) begin
            bad++;
            $display("FAIL sat_255: err_cnt=%0d after 299 mismatches, want 255", err_cnt);
        end
        word_rdy = 1'b0;
    endtask
`else
    task automatic test_seq_disabled();
        apply_reset();
        word_rdy = 1'b1;
        send_nib(4'h6);
        send_nib(4'h7);
        send_nib(4'h0);
        send_nib(4'h2);
        total++;
        if (seq_err !== 1'b0 || err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL seq_tied: seq_err=%b err_cnt=%0d, want 0 / 0", seq_err, err_cnt);
        end
        word_rdy = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_reset_mid();
`ifdef SEQ_CHECK_EN
        test_seq_check();
        test_saturate();
`else
        test_seq_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
